// File: rtl/prio_irq_encoder.sv
// Registered priority encoder: rising edges on request lines latch pending bits.
// The winner is offered on a valid/ready port, and the handshake clears that bit.
module prio_irq_encoder #(
    parameter int N       = 8,
    parameter int RR_MODE = 0,
    parameter int IDX_W   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     mask_i,
    input  logic             clr_all_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_multi,
    output logic [N-1:0]     pending_o
);

    typedef enum logic {S_IDLE, S_PRESENT} state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_req_q;
    logic [N-1:0]     r_pend;
    logic [N-1:0]     w_pend_nxt;
    logic [N-1:0]     w_edge;
    logic [N-1:0]     w_ack;
    logic [N-1:0]     w_elig;
    logic [N-1:0]     w_lo;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] r_rr_last;
    logic [IDX_W-1:0] w_rr_nxt;
    logic [IDX_W-1:0] w_sel;
    logic             r_multi;
    logic             w_multi_nxt;
    logic             w_hs;
    logic             w_any;
    logic             w_many;

    function automatic logic [IDX_W-1:0] f_top(input logic [N-1:0] v);
        logic [IDX_W-1:0] res;
        res = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) res = IDX_W'(i);
        end
        return res;
    endfunction

    assign w_edge = req_i & ~r_req_q;
    assign w_hs   = (r_state == S_PRESENT) && out_ready;
    assign w_ack  = w_hs ? (ONE << r_idx) : '0;
    assign w_elig = r_pend & ~mask_i & ~w_ack;
    assign w_any  = |w_elig;
    assign w_many = |(w_elig & (w_elig - ONE));

    // Round-robin: indices below rr_last come first (descending), then the
    // rest descending, which leaves rr_last itself as the last candidate.
    always_comb begin
        w_lo = '0;
        for (int i = 0; i < N; i++) begin
            w_lo[i] = w_elig[i] && (IDX_W'(i) < r_rr_last);
        end
    end

    assign w_sel = (RR_MODE != 0 && (|w_lo)) ? f_top(w_lo) : f_top(w_elig);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_multi_nxt = r_multi;
        w_pend_nxt  = (r_pend & ~w_ack) | w_edge;
        w_rr_nxt    = w_hs ? r_idx : r_rr_last;
        if (clr_all_i) begin
            w_pend_nxt  = '0;
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        w_idx_nxt   = w_sel;
                        w_multi_nxt = w_many;
                        w_state_nxt = S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (w_hs) begin
                        if (w_any) begin
                            w_idx_nxt   = w_sel;
                            w_multi_nxt = w_many;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_req_q   <= '0;
            r_pend    <= '0;
            r_idx     <= '0;
            r_multi   <= 1'b0;
            r_rr_last <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_q   <= req_i;
            r_pend    <= w_pend_nxt;
            r_idx     <= w_idx_nxt;
            r_multi   <= w_multi_nxt;
            r_rr_last <= w_rr_nxt;
        end
    end

    assign out_valid = (r_state == S_PRESENT);
    assign out_idx   = r_idx;
    assign out_multi = r_multi;
    assign pending_o = r_pend;

endmodule

// File: tb/tb_prio_irq_encoder.sv
// Bench for prio_irq_encoder: fixed and round-robin N=8 instances share stimulus,
// plus an N=5 round-robin instance; all are tracked by a behavioural model.
module tb_prio_irq_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] t_req = '0, t_mask = '0;
    logic       t_clr = 1'b0, t_rdy = 1'b0;
    logic [4:0] u_req = '0, u_mask = '0;
    logic       u_clr = 1'b0, u_rdy = 1'b0;

    logic       d0_valid, d0_multi, d1_valid, d1_multi, d2_valid, d2_multi;
    logic [2:0] d0_idx, d1_idx, d2_idx;
    logic [7:0] d0_pend, d1_pend;
    logic [4:0] d2_pend;

    prio_irq_encoder #(.N(8), .RR_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(t_req), .mask_i(t_mask),
        .clr_all_i(t_clr), .out_valid(d0_valid), .out_ready(t_rdy),
        .out_idx(d0_idx), .out_multi(d0_multi), .pending_o(d0_pend));

    prio_irq_encoder #(.N(8), .RR_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_i(t_req), .mask_i(t_mask),
        .clr_all_i(t_clr), .out_valid(d1_valid), .out_ready(t_rdy),
        .out_idx(d1_idx), .out_multi(d1_multi), .pending_o(d1_pend));

    prio_irq_encoder #(.N(5), .RR_MODE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_i(u_req), .mask_i(u_mask),
        .clr_all_i(u_clr), .out_valid(d2_valid), .out_ready(u_rdy),
        .out_idx(d2_idx), .out_multi(d2_multi), .pending_o(d2_pend));

    int total = 0;
    int bad = 0;

    // Reference model state, one slot per instance
    logic [63:0] m_pend [3];
    logic [63:0] m_reqq [3];
    bit          m_valid[3];
    bit          m_multi[3];
    int          m_idx  [3];
    int          m_rr   [3];

    function automatic int mn(int k);
        return (k == 2) ? 5 : 8;
    endfunction

    function automatic int mrr(int k);
        return (k == 0) ? 0 : 1;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pend[k] = '0; m_reqq[k] = '0; m_valid[k] = 0;
            m_multi[k] = 0; m_idx[k] = 0; m_rr[k] = 0;
        end
    endtask

    task automatic model_edge(int k, logic [63:0] req, logic [63:0] mask,
                              bit clr, bit rdy);
        int n, oi, pick, cnt;
        logic [63:0] all, rise, cand;
        bit hs;
        n = mn(k);
        all = (64'd1 << n) - 64'd1;
        rise = req & ~m_reqq[k] & all;
        hs = m_valid[k] && rdy;
        oi = m_idx[k];
        cand = m_pend[k] & ~mask & all;
        if (hs) cand[oi] = 1'b0;
        cnt = 0;
        pick = -1;
        for (int i = 0; i < n; i++) if (cand[i]) cnt++;
        if (mrr(k) == 0) begin
            for (int i = n - 1; i >= 0; i--)
                if (cand[i] && pick < 0) pick = i;
        end else begin
            for (int s = 1; s <= n; s++) begin
                int j;
                j = (m_rr[k] - s + n) % n;
                if (cand[j] && pick < 0) pick = j;
            end
        end
        if (clr) begin
            m_pend[k] = '0;
            m_valid[k] = 0;
        end else begin
            if (hs) m_pend[k][oi] = 1'b0;
            m_pend[k] = m_pend[k] | rise;
            if (!m_valid[k] || hs) begin
                if (pick >= 0) begin
                    m_valid[k] = 1;
                    m_idx[k] = pick;
                    m_multi[k] = (cnt > 1);
                end else begin
                    m_valid[k] = 0;
                end
            end
        end
        if (hs) m_rr[k] = oi;
        m_reqq[k] = req & all;
    endtask

    task automatic model_check(int k);
        logic av, am;
        logic [63:0] ai, ap;
        case (k)
            0: begin av = d0_valid; am = d0_multi; ai = 64'(d0_idx); ap = 64'(d0_pend); end
            1: begin av = d1_valid; am = d1_multi; ai = 64'(d1_idx); ap = 64'(d1_pend); end
            default: begin av = d2_valid; am = d2_multi; ai = 64'(d2_idx); ap = 64'(d2_pend); end
        endcase
        chk($sformatf("m%0d_valid", k), 64'(av), 64'(m_valid[k]));
        chk($sformatf("m%0d_pend", k), ap, m_pend[k]);
        if (m_valid[k]) begin
            chk($sformatf("m%0d_idx", k), ai, 64'(m_idx[k]));
            chk($sformatf("m%0d_multi", k), 64'(am), 64'(m_multi[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, 64'(t_req), 64'(t_mask), t_clr, t_rdy);
        model_edge(1, 64'(t_req), 64'(t_mask), t_clr, t_rdy);
        model_edge(2, 64'(u_req), 64'(u_mask), u_clr, u_rdy);
        #1;
        for (int k = 0; k < 3; k++) model_check(k);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        bit         rdy;
        bit         ev;
        int         eidx;
        bit         em;
        logic [7:0] ep;
    } vec_t;

    vec_t tbl[10];

    initial begin
        bit found;
        tbl[0] = '{8'h12, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h12};
        tbl[1] = '{8'h00, 8'h00, 1'b1, 1'b1, 4, 1'b1, 8'h12};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 1'b1, 1, 1'b0, 8'h02};
        tbl[3] = '{8'h00, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};
        tbl[4] = '{8'hC0, 8'h80, 1'b1, 1'b0, 0, 1'b0, 8'hC0};
        tbl[5] = '{8'h00, 8'h80, 1'b1, 1'b1, 6, 1'b0, 8'hC0};
        tbl[6] = '{8'h00, 8'h80, 1'b1, 1'b0, 0, 1'b0, 8'h80};
        tbl[7] = '{8'h00, 8'h80, 1'b1, 1'b0, 0, 1'b0, 8'h80};
        tbl[8] = '{8'h00, 8'h00, 1'b1, 1'b1, 7, 1'b0, 8'h80};
        tbl[9] = '{8'h00, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};

        model_reset();
        #12;
        chk("rst_valid0", 64'(d0_valid), 0);
        chk("rst_idx0", 64'(d0_idx), 0);
        chk("rst_multi0", 64'(d0_multi), 0);
        chk("rst_pend0", 64'(d0_pend), 0);
        chk("rst_valid1", 64'(d1_valid), 0);
        chk("rst_pend2", 64'(d2_pend), 0);
        rst_n = 1'b1;
        step();

        // Round-robin versus fixed priority from a fresh rr_last
        t_rdy = 1'b1;
        t_req = 8'h85;
        step();
        chk("rr_pend", 64'(d0_pend), 64'h85);
        t_req = 8'h00;
        step();
        chk("rr_g0_f", 64'(d0_idx), 7);
        chk("rr_g0_r", 64'(d1_idx), 7);
        t_req = 8'h80;
        step();
        chk("rr_g1_f", 64'(d0_idx), 2);
        chk("rr_g1_r", 64'(d1_idx), 2);
        chk("rr_keep7", 64'(d0_pend), 64'h85);
        t_req = 8'h00;
        step();
        chk("rr_g2_f", 64'(d0_idx), 7);
        chk("rr_g2_r", 64'(d1_idx), 0);
        step();
        chk("rr_g3_f", 64'(d0_idx), 0);
        chk("rr_g3_r", 64'(d1_idx), 7);
        chk("rr_g3_v", 64'(d1_valid), 1);
        step();
        chk("rr_done", 64'({d0_valid, d1_valid}), 0);

        // Fixed-priority burst and masking, cycle by cycle
        for (int i = 0; i < 10; i++) begin
            t_req = tbl[i].req;
            t_mask = tbl[i].mask;
            t_rdy = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_valid", i), 64'(d0_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_pend", i), 64'(d0_pend), 64'(tbl[i].ep));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_idx", i), 64'(d0_idx), 64'(tbl[i].eidx));
                chk($sformatf("tbl%0d_multi", i), 64'(d0_multi), 64'(tbl[i].em));
            end
        end

        // Stability under back-pressure
        t_rdy = 1'b0;
        t_req = 8'h02;
        step();
        t_req = 8'h00;
        step();
        chk("stab_first", 64'(d0_idx), 1);
        t_req = 8'h80;
        step();
        t_req = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("stab_hold%0d", i), 64'({d0_valid, d0_idx}), 64'({1'b1, 3'd1}));
        end
        t_rdy = 1'b1;
        step();
        chk("stab_next", 64'({d0_valid, d0_idx}), 64'({1'b1, 3'd7}));
        step();
        chk("stab_empty", 64'(d0_valid), 0);

        // Acknowledge colliding with a new edge on the same line
        t_rdy = 1'b0;
        t_req = 8'h08;
        step();
        t_req = 8'h00;
        step();
        chk("coll_pres", 64'(d0_idx), 3);
        t_rdy = 1'b1;
        t_req = 8'h08;
        step();
        chk("coll_pend", 64'(d0_pend[3]), 1);
        t_req = 8'h00;
        found = 0;
        for (int i = 0; i < 3 && !found; i++) begin
            step();
            if (d0_valid && d0_idx == 3'd3) found = 1;
        end
        chk("coll_repr", 64'(found), 1);
        step();
        chk("coll_end", 64'({d0_valid, d0_pend}), 0);

        // Abort while a grant is being accepted
        t_rdy = 1'b0;
        t_req = 8'hF0;
        step();
        t_req = 8'h00;
        step();
        chk("abort_pre", 64'({d0_valid, d0_idx, d0_pend}), 64'({1'b1, 3'd7, 8'hF0}));
        t_clr = 1'b1;
        t_rdy = 1'b1;
        step();
        chk("abort_v", 64'(d0_valid), 0);
        chk("abort_p", 64'(d0_pend), 0);
        t_clr = 1'b0;
        step();
        chk("abort_idle", 64'(d0_valid), 0);

        // Asynchronous reset in the middle of a presentation
        t_rdy = 1'b0;
        t_req = 8'h30;
        step();
        t_req = 8'h00;
        step();
        chk("arst_pre", 64'({d0_valid, d0_idx}), 64'({1'b1, 3'd5}));
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_v", 64'({d0_valid, d1_valid}), 0);
        chk("arst_i", 64'({d0_idx, d1_idx}), 0);
        chk("arst_p", 64'({d0_pend, d1_pend}), 0);
        model_reset();
        #1;
        rst_n = 1'b1;

        // Randomised traffic against the model
        for (int c = 0; c < 800; c++) begin
            t_req ^= 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 7) == 0) t_mask = 8'($urandom & $urandom);
            t_rdy = ($urandom_range(0, 3) != 0);
            t_clr = ($urandom_range(0, 60) == 0);
            u_req ^= 5'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 7) == 0) u_mask = 5'($urandom & $urandom);
            u_rdy = ($urandom_range(0, 2) != 0);
            u_clr = ($urandom_range(0, 60) == 0);
            step();
            if (c == 400) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
